// File: rtl/rtc_bus_interface.sv
// Bus master for a multiplexed address/data RTC chip.
// A 40-cycle sequencer drives the strobes, and a capture stage stores the bytes read back.
module rtc_bus_interface #(
  parameter int T_LEN    = 40,
  parameter int T_SAMPLE = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       IndicadorMaquina,
  input  logic [7:0] address,
  input  logic [7:0] DATA_WRITE,
  input  logic       camb_hora,
  input  logic       camb_fecha,
  input  logic       camb_crono,
  output logic       ChipSelect,
  output logic       Write,
  output logic       Read,
  output logic       AoD,
  inout  wire  [7:0] DATA_ADDRESS,
  output logic [7:0] data_vga,
  output logic [7:0] contador2,
  output logic       bit_inicio,
  output logic [7:0] data_vga_final,
  output logic [3:0] contador_datos
);

  localparam logic [7:0] LAST   = 8'(T_LEN - 1);
  localparam logic [7:0] SAMPLE = 8'(T_SAMPLE);
  localparam logic [7:0] COMMIT = 8'(T_SAMPLE + 1);
  localparam logic [3:0] IDX_LAST = 4'd8;

  logic [7:0] cnt_q, cnt_d;
  logic       mode_q;
  logic [7:0] addr_q, data_q;
  logic [3:0] idx_q, idx_d;
  logic       cs_q, cs_d;
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic       aod_q, aod_d;
  logic       drv_q, drv_d;
  logic [7:0] bus_q, bus_d;
  logic [7:0] vga_q, fin_q;
  logic       ini_q, ini_d;
  logic [7:0] rd_addr;
  logic       suppress;

  always_comb begin
    unique case (idx_q)
      4'd0:    rd_addr = 8'h21;
      4'd1:    rd_addr = 8'h22;
      4'd2:    rd_addr = 8'h23;
      4'd3:    rd_addr = 8'h24;
      4'd4:    rd_addr = 8'h25;
      4'd5:    rd_addr = 8'h26;
      4'd6:    rd_addr = 8'h41;
      4'd7:    rd_addr = 8'h42;
      4'd8:    rd_addr = 8'h43;
      default: rd_addr = 8'h21;
    endcase
  end

  always_comb begin
    suppress = 1'b0;
    unique case (1'b1)
      (idx_q <= 4'd2): suppress = camb_hora;
      (idx_q >= 4'd3 && idx_q <= 4'd5): suppress = camb_fecha;
      default: suppress = camb_crono;
    endcase
  end

  always_comb begin
    cnt_d = (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
    idx_d = idx_q;
    if (cnt_q == LAST && !mode_q)
      idx_d = (idx_q == IDX_LAST) ? 4'd0 : idx_q + 4'd1;
  end

  // Strobes are computed from the next count so the registered
  // values line up with the cycle carrying that count.
  always_comb begin
    cs_d  = 1'b1;
    wr_d  = 1'b1;
    rd_d  = 1'b1;
    aod_d = 1'b1;
    drv_d = 1'b0;
    bus_d = 8'h00;
    ini_d = (cnt_d == 8'd0) && !IndicadorMaquina && (idx_d == 4'd0);
    if (cnt_d >= 8'd2 && cnt_d <= 8'd11) begin
      cs_d  = 1'b0;
      aod_d = 1'b0;
      drv_d = 1'b1;
      bus_d = addr_q;
      if (cnt_d >= 8'd4 && cnt_d <= 8'd9)
        wr_d = 1'b0;
    end else if (cnt_d >= 8'd18 && cnt_d <= 8'd29) begin
      cs_d = 1'b0;
      if (mode_q) begin
        drv_d = 1'b1;
        bus_d = data_q;
        if (cnt_d >= 8'd20 && cnt_d <= 8'd27)
          wr_d = 1'b0;
      end else if (cnt_d >= 8'd20 && cnt_d <= 8'd27) begin
        rd_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= 8'd0;
      mode_q <= 1'b1;
      addr_q <= 8'h00;
      data_q <= 8'h00;
      idx_q  <= 4'd0;
      cs_q   <= 1'b1;
      wr_q   <= 1'b1;
      rd_q   <= 1'b1;
      aod_q  <= 1'b1;
      drv_q  <= 1'b0;
      bus_q  <= 8'h00;
      vga_q  <= 8'h00;
      fin_q  <= 8'h00;
      ini_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      cs_q  <= cs_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      aod_q <= aod_d;
      drv_q <= drv_d;
      bus_q <= bus_d;
      ini_q <= ini_d;
      if (cnt_q == 8'd0) begin
        mode_q <= IndicadorMaquina;
        addr_q <= IndicadorMaquina ? address : rd_addr;
        data_q <= DATA_WRITE;
      end
      if (!mode_q && cnt_q == SAMPLE)
        vga_q <= DATA_ADDRESS;
      if (!mode_q && cnt_q == COMMIT && !suppress)
        fin_q <= vga_q;
    end
  end

  assign DATA_ADDRESS   = drv_q ? bus_q : 8'bz;
  assign ChipSelect     = cs_q;
  assign Write          = wr_q;
  assign Read           = rd_q;
  assign AoD            = aod_q;
  assign data_vga       = vga_q;
  assign data_vga_final = fin_q;
  assign contador2      = cnt_q;
  assign bit_inicio     = ini_q;
  assign contador_datos = idx_q;

endmodule

// File: tb/tb_rtc_bus_interface.sv
// Directed bench for rtc_bus_interface with a small RTC chip model.
// The bus pulls up to 0xFF whenever nobody drives it.
module tb_rtc_bus_interface;

  logic       clk = 1'b0;
  logic       reset;
  logic       IndicadorMaquina;
  logic [7:0] address;
  logic [7:0] DATA_WRITE;
  logic       camb_hora, camb_fecha, camb_crono;
  logic       ChipSelect, Write, Read, AoD;
  wire  [7:0] DATA_ADDRESS;
  logic [7:0] data_vga, contador2, data_vga_final;
  logic       bit_inicio;
  logic [3:0] contador_datos;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] mem [0:255];
  logic [7:0] rtc_addr = 8'h00;
  logic [7:0] addr_tbl [0:8];
  logic [7:0] val_tbl  [0:8];

  always #5 clk = ~clk;

  rtc_bus_interface dut (
    .clk(clk), .reset(reset),
    .IndicadorMaquina(IndicadorMaquina),
    .address(address), .DATA_WRITE(DATA_WRITE),
    .camb_hora(camb_hora), .camb_fecha(camb_fecha),
    .camb_crono(camb_crono),
    .ChipSelect(ChipSelect), .Write(Write),
    .Read(Read), .AoD(AoD),
    .DATA_ADDRESS(DATA_ADDRESS),
    .data_vga(data_vga), .contador2(contador2),
    .bit_inicio(bit_inicio),
    .data_vga_final(data_vga_final),
    .contador_datos(contador_datos)
  );

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (DATA_ADDRESS[g]);
  end

  // RTC: address latched on Write rising in the address phase,
  // data stored on Write rising in the data phase.
  always @(posedge Write) begin
    if (!ChipSelect) begin
      if (!AoD) rtc_addr = DATA_ADDRESS;
      else mem[rtc_addr] = DATA_ADDRESS;
    end
  end

  assign DATA_ADDRESS = (!ChipSelect && !Read) ? mem[rtc_addr] : 8'bz;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic wait_cnt(input logic [7:0] k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (contador2 !== k && n < 100);
    nvec++;
    assert (contador2 === k) else begin
      nerr++;
      $error("FAIL wait_cnt: observed %02h expected %02h", contador2, k);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cs"}, {7'd0, ChipSelect}, 8'd1);
    chk({tag, "_wr"}, {7'd0, Write}, 8'd1);
    chk({tag, "_rd"}, {7'd0, Read}, 8'd1);
    chk({tag, "_aod"}, {7'd0, AoD}, 8'd1);
    chk({tag, "_bus"}, DATA_ADDRESS, 8'hFF);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    addr_tbl[0] = 8'h21; val_tbl[0] = 8'h35;
    addr_tbl[1] = 8'h22; val_tbl[1] = 8'h12;
    addr_tbl[2] = 8'h23; val_tbl[2] = 8'h08;
    addr_tbl[3] = 8'h24; val_tbl[3] = 8'h15;
    addr_tbl[4] = 8'h25; val_tbl[4] = 8'h06;
    addr_tbl[5] = 8'h26; val_tbl[5] = 8'h24;
    addr_tbl[6] = 8'h41; val_tbl[6] = 8'h05;
    addr_tbl[7] = 8'h42; val_tbl[7] = 8'h03;
    addr_tbl[8] = 8'h43; val_tbl[8] = 8'h01;
    for (int i = 0; i < 9; i++) mem[addr_tbl[i]] = val_tbl[i];

    reset = 1'b1;
    IndicadorMaquina = 1'b1;
    address = 8'h0A;
    DATA_WRITE = 8'h0F;
    camb_hora = 1'b0;
    camb_fecha = 1'b0;
    camb_crono = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cnt", contador2, 8'd0);
    chk_idle("rst");
    chk("rst_vga", data_vga, 8'h00);
    chk("rst_fin", data_vga_final, 8'h00);
    chk("rst_idx", {4'd0, contador_datos}, 8'd0);
    chk("rst_ini", {7'd0, bit_inicio}, 8'd0);
    reset = 1'b0;

    // reset in the middle of a write data phase
    wait_cnt(8'd20);
    chk("pre_wr", {7'd0, Write}, 8'd0);
    chk("pre_bus", DATA_ADDRESS, 8'h0F);
    reset = 1'b1;
    #1;
    chk_idle("mid");
    chk("mid_cnt", contador2, 8'd0);
    chk("mid_idx", {4'd0, contador_datos}, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    // write transaction 0x0F -> 0x0A
    wait_cnt(8'd1);
    chk_idle("w1");
    wait_cnt(8'd2);
    chk("w2_bus", DATA_ADDRESS, 8'h0A);
    chk("w2_cs", {7'd0, ChipSelect}, 8'd0);
    chk("w2_aod", {7'd0, AoD}, 8'd0);
    chk("w2_wr", {7'd0, Write}, 8'd1);
    wait_cnt(8'd4);
    chk("w4_wr", {7'd0, Write}, 8'd0);
    wait_cnt(8'd9);
    chk("w9_wr", {7'd0, Write}, 8'd0);
    wait_cnt(8'd10);
    chk("w10_wr", {7'd0, Write}, 8'd1);
    wait_cnt(8'd11);
    chk("w11_bus", DATA_ADDRESS, 8'h0A);
    wait_cnt(8'd12);
    chk_idle("w12");
    wait_cnt(8'd18);
    chk("w18_bus", DATA_ADDRESS, 8'h0F);
    chk("w18_aod", {7'd0, AoD}, 8'd1);
    chk("w18_cs", {7'd0, ChipSelect}, 8'd0);
    chk("w18_wr", {7'd0, Write}, 8'd1);
    wait_cnt(8'd20);
    chk("w20_wr", {7'd0, Write}, 8'd0);
    chk("w20_rd", {7'd0, Read}, 8'd1);
    wait_cnt(8'd27);
    chk("w27_wr", {7'd0, Write}, 8'd0);
    wait_cnt(8'd28);
    chk("w28_wr", {7'd0, Write}, 8'd1);
    chk("w28_bus", DATA_ADDRESS, 8'h0F);
    wait_cnt(8'd30);
    chk_idle("w30");
    chk("w_mem", mem[8'h0A], 8'h0F);
    IndicadorMaquina = 1'b0;
    wait_cnt(8'd39);
    chk("w_idx", {4'd0, contador_datos}, 8'd0);

    // first read of the sweep: 0x21 returns 0x35
    wait_cnt(8'd0);
    chk("r0_ini", {7'd0, bit_inicio}, 8'd1);
    wait_cnt(8'd1);
    chk("r1_ini", {7'd0, bit_inicio}, 8'd0);
    wait_cnt(8'd3);
    chk("r3_bus", DATA_ADDRESS, 8'h21);
    chk("r3_aod", {7'd0, AoD}, 8'd0);
    wait_cnt(8'd19);
    chk("r19_bus", DATA_ADDRESS, 8'hFF);
    chk("r19_rd", {7'd0, Read}, 8'd1);
    wait_cnt(8'd20);
    chk("r20_rd", {7'd0, Read}, 8'd0);
    chk("r20_wr", {7'd0, Write}, 8'd1);
    chk("r20_bus", DATA_ADDRESS, 8'h35);
    wait_cnt(8'd27);
    chk("r27_rd", {7'd0, Read}, 8'd0);
    chk("r27_vga", data_vga, 8'h35);
    chk("r27_fin", data_vga_final, 8'h00);
    wait_cnt(8'd28);
    chk("r28_rd", {7'd0, Read}, 8'd1);
    chk("r28_fin", data_vga_final, 8'h35);
    wait_cnt(8'd39);
    chk("r39_idx", {4'd0, contador_datos}, 8'd0);
    camb_hora = 1'b1;

    // rest of the sweep with time editing active
    for (int i = 1; i < 9; i++) begin
      wait_cnt(8'd0);
      chk($sformatf("s%0d_idx", i), {4'd0, contador_datos}, 8'(i));
      chk($sformatf("s%0d_ini", i), {7'd0, bit_inicio}, 8'd0);
      wait_cnt(8'd3);
      chk($sformatf("s%0d_adr", i), DATA_ADDRESS, addr_tbl[i]);
      wait_cnt(8'd28);
      chk($sformatf("s%0d_vga", i), data_vga, val_tbl[i]);
      chk($sformatf("s%0d_fin", i), data_vga_final,
          (i <= 2) ? 8'h35 : val_tbl[i]);
    end
    wait_cnt(8'd0);
    chk("wrap_idx", {4'd0, contador_datos}, 8'd0);
    chk("wrap_ini", {7'd0, bit_inicio}, 8'd1);
    camb_hora = 1'b0;

    // mode change mid-transaction takes effect next transaction
    wait_cnt(8'd15);
    IndicadorMaquina = 1'b1;
    address = 8'h30;
    DATA_WRITE = 8'h5A;
    wait_cnt(8'd20);
    chk("t20_rd", {7'd0, Read}, 8'd0);
    chk("t20_wr", {7'd0, Write}, 8'd1);
    wait_cnt(8'd28);
    chk("t28_vga", data_vga, 8'h35);
    wait_cnt(8'd0);
    chk("t0_idx", {4'd0, contador_datos}, 8'd1);
    chk("t0_ini", {7'd0, bit_inicio}, 8'd0);
    wait_cnt(8'd3);
    chk("t3_bus", DATA_ADDRESS, 8'h30);
    wait_cnt(8'd20);
    chk("t20w_wr", {7'd0, Write}, 8'd0);
    chk("t20w_rd", {7'd0, Read}, 8'd1);
    chk("t20w_bus", DATA_ADDRESS, 8'h5A);
    wait_cnt(8'd30);
    chk("t_mem", mem[8'h30], 8'h5A);
    chk("t_vga", data_vga, 8'h35);
    wait_cnt(8'd0);
    chk("t_idx", {4'd0, contador_datos}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
